// File: rtl/ysyx_l1i_cache_if.sv
// Instruction-bus read channel between the L1I cache (master) and the memory side (slave).
// Carries the read-address handshake with burst length and the returning data beats.
interface ysyx_l1i_cache_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [7:0]        arlen;
    logic              arready;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              rlast;

    modport master (
        output araddr, arvalid, arlen,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, arlen,
        output arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/ysyx_l1i_cache.sv
// Direct-mapped L1 instruction cache with burst or single-beat line refill,
// deferred fence.i invalidation and saturating hit/miss counters.
module ysyx_l1i_cache #(
    parameter int              ADDR_W      = 32,
    parameter int              SETS        = 4,
    parameter int              LINE_WORDS  = 2,
    parameter logic [ADDR_W-1:0] BURST_BASE  = 'ha0000000,
    parameter logic [ADDR_W-1:0] BURST_LIMIT = 'hc0000000,
    parameter bit              BURST_EN    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic               req_i,
    input  logic               invalidate_i,
    output logic [31:0]        inst_o,
    output logic               hit_o,
    output logic               ready_o,
    output logic               required_o,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o,
    ysyx_l1i_cache_if.master   bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FILL} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  base_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [OFF_W-1:0]   beat_reg;
    logic               burst_reg;
    logic               flush_pend_reg;
    logic [SETS-1:0]    valid_reg, valid_next;
    logic [31:0]        hit_cnt_reg, miss_cnt_reg;

    logic [31:0]        data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]   tag_mem  [SETS];

    logic [TAG_W-1:0]   pc_tag;
    logic [IDX_W-1:0]   pc_idx;
    logic [OFF_W-1:0]   pc_off;
    logic [ADDR_W-1:0]  pc_base;
    logic               pc_burst;
    logic               miss_start;
    logic               beat_wr;
    logic               clear_all;
    logic               unused_pc;

    assign pc_tag   = pc_i[ADDR_W-1 -: TAG_W];
    assign pc_idx   = pc_i[IDX_W+OFF_W+1 : OFF_W+2];
    assign pc_off   = pc_i[OFF_W+1 : 2];
    assign pc_base  = {pc_i[ADDR_W-1 : OFF_W+2], {(OFF_W+2){1'b0}}};
    assign pc_burst = BURST_EN && (pc_base >= BURST_BASE) && (pc_base <= BURST_LIMIT);
    assign unused_pc = &{1'b0, pc_i[1:0]};

    assign hit_o      = (state_reg == IDLE) && valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign inst_o     = data_mem[{pc_idx, pc_off}];
    assign ready_o    = (state_reg == IDLE);
    assign required_o = (state_reg != IDLE);
    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;

    assign bus.arvalid = (state_reg == ADDR);
    assign bus.araddr  = base_reg | (ADDR_W'(beat_reg) << 2);
    assign bus.arlen   = burst_reg ? 8'(LINE_WORDS - 1) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        miss_start = 1'b0;
        beat_wr    = 1'b0;
        case (state_reg)
            IDLE: if (req_i && !hit_o) begin
                miss_start = 1'b1;
                state_next = ADDR;
            end
            ADDR: if (bus.arready) state_next = DATA;
            DATA: if (bus.rvalid) begin
                beat_wr = 1'b1;
                if (burst_reg) begin
                    if (beat_reg == LAST_BEAT || bus.rlast) state_next = FILL;
                end else begin
                    state_next = (beat_reg == LAST_BEAT) ? FILL : ADDR;
                end
            end
            FILL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A flush seen while busy is held until FILL, which then drops every line
    // including the one just refilled.
    assign clear_all = ((state_reg == IDLE) && invalidate_i) ||
                       ((state_reg == FILL) && (flush_pend_reg || invalidate_i));

    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        assign valid_next[gi] = clear_all                                      ? 1'b0 :
                                (miss_start && pc_idx == IDX_W'(gi))            ? 1'b0 :
                                ((state_reg == FILL) && idx_reg == IDX_W'(gi))  ? 1'b1 :
                                valid_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= '0;
            flush_pend_reg <= 1'b0;
            hit_cnt_reg    <= '0;
            miss_cnt_reg   <= '0;
            base_reg       <= '0;
            tag_reg        <= '0;
            idx_reg        <= '0;
            beat_reg       <= '0;
            burst_reg      <= 1'b0;
        end else begin
            valid_reg <= valid_next;
            if (state_reg == FILL)
                flush_pend_reg <= 1'b0;
            else if (state_reg != IDLE && invalidate_i)
                flush_pend_reg <= 1'b1;
            if (miss_start) begin
                base_reg  <= pc_base;
                tag_reg   <= pc_tag;
                idx_reg   <= pc_idx;
                beat_reg  <= '0;
                burst_reg <= pc_burst;
            end else if (beat_wr) begin
                beat_reg <= beat_reg + 1'b1;
            end
            if (req_i && hit_o && hit_cnt_reg != '1)
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (miss_start && miss_cnt_reg != '1)
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    // Storage carries no reset; stale contents are masked by the valid bits.
    always_ff @(posedge clk) begin
        if (beat_wr)
            data_mem[{idx_reg, beat_reg}] <= bus.rdata;
        if (state_reg == FILL)
            tag_mem[idx_reg] <= tag_reg;
    end
endmodule

// File: tb/tb_ysyx_l1i_cache.sv
// Directed bench for ysyx_l1i_cache: a 4-set/2-word instance and a 16-set/8-word
// instance, each on a zero-wait memory model with optional address stall.
module tb_ysyx_l1i_cache;
    logic clk = 1'b0;
    logic rst;
    logic inv;
    logic ar_stall;
    logic [31:0] pc0, pc1;
    logic req0, req1;
    logic [31:0] inst0, inst1, hit_cnt0, hit_cnt1, miss_cnt0, miss_cnt1;
    logic hit0, hit1, ready0, ready1, required0, required1;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_l1i_cache_if #(.ADDR_W(32)) bus0 ();
    ysyx_l1i_cache_if #(.ADDR_W(32)) bus1 ();

    ysyx_l1i_cache #(.ADDR_W(32), .SETS(4), .LINE_WORDS(2)) u_dut0 (
        .clk(clk), .rst(rst), .pc_i(pc0), .req_i(req0), .invalidate_i(inv),
        .inst_o(inst0), .hit_o(hit0), .ready_o(ready0), .required_o(required0),
        .hit_cnt_o(hit_cnt0), .miss_cnt_o(miss_cnt0), .bus(bus0)
    );

    ysyx_l1i_cache #(.ADDR_W(32), .SETS(16), .LINE_WORDS(8)) u_dut1 (
        .clk(clk), .rst(rst), .pc_i(pc1), .req_i(req1), .invalidate_i(inv),
        .inst_o(inst1), .hit_o(hit1), .ready_o(ready1), .required_o(required1),
        .hit_cnt_o(hit_cnt1), .miss_cnt_o(miss_cnt1), .bus(bus1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    logic        bus_arvalid [2];
    logic [31:0] bus_araddr  [2];
    logic [7:0]  bus_arlen   [2];
    logic        bus_arready [2];
    logic [31:0] bus_rdata   [2];
    logic        bus_rvalid  [2];
    logic        bus_rlast   [2];

    assign bus_arvalid[0] = bus0.arvalid;
    assign bus_araddr[0]  = bus0.araddr;
    assign bus_arlen[0]   = bus0.arlen;
    assign bus0.arready   = bus_arready[0];
    assign bus0.rdata     = bus_rdata[0];
    assign bus0.rvalid    = bus_rvalid[0];
    assign bus0.rlast     = bus_rlast[0];
    assign bus_arvalid[1] = bus1.arvalid;
    assign bus_araddr[1]  = bus1.araddr;
    assign bus_arlen[1]   = bus1.arlen;
    assign bus1.arready   = bus_arready[1];
    assign bus1.rdata     = bus_rdata[1];
    assign bus1.rvalid    = bus_rvalid[1];
    assign bus1.rlast     = bus_rlast[1];

    // Memory model: an accepted request streams arlen+1 beats starting the next cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bus
        int          beats_left;
        logic [31:0] beat_addr;
        int          ar_cnt;
        logic [31:0] ar_addr_log [8];
        logic [7:0]  ar_len_log  [8];
        always @(posedge clk) begin
            if (rst) begin
                beats_left <= 0;
                beat_addr  <= '0;
                ar_cnt     <= 0;
            end else if (bus_arvalid[gi] && bus_arready[gi]) begin
                beats_left <= int'(bus_arlen[gi]) + 1;
                beat_addr  <= bus_araddr[gi];
                ar_addr_log[ar_cnt[2:0]] <= bus_araddr[gi];
                ar_len_log[ar_cnt[2:0]]  <= bus_arlen[gi];
                ar_cnt <= ar_cnt + 1;
            end else if (beats_left > 0) begin
                beats_left <= beats_left - 1;
                beat_addr  <= beat_addr + 32'd4;
            end
        end
        assign bus_arready[gi] = !ar_stall;
        assign bus_rvalid[gi]  = (beats_left > 0);
        assign bus_rlast[gi]   = (beats_left == 1);
        assign bus_rdata[gi]   = mem_word(beat_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; inv = 1'b0; ar_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Holds req until hit_o; lat is the cycle index of the hit (0 = same cycle), -1 on timeout.
    task automatic fetch(input int sel, input logic [31:0] a, output int lat, output logic [31:0] ins);
        @(posedge clk); #1;
        if (sel == 0) begin pc0 = a; req0 = 1'b1; end
        else          begin pc1 = a; req1 = 1'b1; end
        lat = -1;
        ins = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (sel == 0 ? hit0 : hit1) begin
                lat = k;
                ins = (sel == 0) ? inst0 : inst1;
                break;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        $display("fetch dut%0d pc=%h latency=%0d inst=%h", sel, a, lat, ins);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] ins;
        rst = 1'b1; inv = 1'b0; ar_stall = 1'b0;
        pc0 = 32'h3000_0000; pc1 = 32'h8000_0000; req0 = 1'b0; req1 = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_required", 32'(required0), 32'd0);
        check("rst_hit", 32'(hit0), 32'd0);
        check("rst_arvalid", 32'(bus0.arvalid), 32'd0);
        check("rst_hit_cnt", hit_cnt0, 32'd0);
        check("rst_miss_cnt", miss_cnt0, 32'd0);

        // Cold fetch outside the burst window: two single-beat requests
        do_reset();
        fetch(0, 32'h3000_0000, lat, ins);
        check("single_lat", 32'(lat), 32'd6);
        check("single_inst", ins, mem_word(32'h3000_0000));
        check("single_ar_cnt", 32'(g_bus[0].ar_cnt), 32'd2);
        check("single_ar0", g_bus[0].ar_addr_log[0], 32'h3000_0000);
        check("single_ar1", g_bus[0].ar_addr_log[1], 32'h3000_0004);
        check("single_len0", 32'(g_bus[0].ar_len_log[0]), 32'd0);
        check("single_len1", 32'(g_bus[0].ar_len_log[1]), 32'd0);
        fetch(0, 32'h3000_0004, lat, ins);
        check("single_w1_lat", 32'(lat), 32'd0);
        check("single_w1_inst", ins, mem_word(32'h3000_0004));
        @(negedge clk);
        check("single_miss_cnt", miss_cnt0, 32'd1);
        check("single_hit_cnt", hit_cnt0, 32'd2);

        // Burst refill inside the window
        do_reset();
        fetch(0, 32'ha000_0008, lat, ins);
        check("burst_lat", 32'(lat), 32'd5);
        check("burst_inst", ins, mem_word(32'ha000_0008));
        check("burst_ar_cnt", 32'(g_bus[0].ar_cnt), 32'd1);
        check("burst_ar0", g_bus[0].ar_addr_log[0], 32'ha000_0008);
        check("burst_len0", 32'(g_bus[0].ar_len_log[0]), 32'd1);
        fetch(0, 32'ha000_000c, lat, ins);
        check("burst_w1_lat", 32'(lat), 32'd0);
        check("burst_w1_inst", ins, mem_word(32'ha000_000c));
        @(negedge clk);
        check("burst_miss_cnt", miss_cnt0, 32'd1);

        // Invalidate in IDLE: old state visible this cycle, cleared next
        @(posedge clk); #1;
        pc0 = 32'ha000_0008; inv = 1'b1;
        @(negedge clk);
        check("inv_idle_same", 32'(hit0), 32'd1);
        @(posedge clk); #1;
        inv = 1'b0;
        @(negedge clk);
        check("inv_idle_after", 32'(hit0), 32'd0);

        // Conflict eviction on a shared index
        do_reset();
        fetch(0, 32'h8000_0000, lat, ins);
        check("evict_a_lat", 32'(lat), 32'd6);
        fetch(0, 32'h8000_0040, lat, ins);
        check("evict_b_lat", 32'(lat), 32'd6);
        check("evict_b_inst", ins, mem_word(32'h8000_0040));
        fetch(0, 32'h8000_0000, lat, ins);
        check("evict_a2_lat", 32'(lat), 32'd6);
        check("evict_a2_inst", ins, mem_word(32'h8000_0000));
        @(negedge clk);
        check("evict_miss_cnt", miss_cnt0, 32'd3);

        // Invalidate during DATA beat 0: refilled line stays invalid, request misses again
        do_reset();
        fork
            fetch(0, 32'ha000_0010, lat, ins);
            begin
                @(posedge clk); @(posedge clk); @(posedge clk); #1;
                inv = 1'b1;
                @(posedge clk); #1;
                inv = 1'b0;
            end
        join
        check("inv_busy_lat", 32'(lat), 32'd10);
        check("inv_busy_inst", ins, mem_word(32'ha000_0010));
        @(negedge clk);
        check("inv_busy_miss_cnt", miss_cnt0, 32'd2);

        // Reset while the address request is pending
        do_reset();
        @(posedge clk); #1;
        ar_stall = 1'b1; pc0 = 32'h3000_0000; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check("pend_arvalid", 32'(bus0.arvalid), 32'd1);
        check("pend_required", 32'(required0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ar_stall = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(ready0), 32'd1);
        check("mid_rst_required", 32'(required0), 32'd0);
        check("mid_rst_hit", 32'(hit0), 32'd0);
        check("mid_rst_arvalid", 32'(bus0.arvalid), 32'd0);
        check("mid_rst_miss_cnt", miss_cnt0, 32'd0);
        check("mid_rst_hit_cnt", hit_cnt0, 32'd0);

        // 16 sets x 8 words: 100 sequential fetches span 13 lines
        do_reset();
        for (int i = 0; i < 100; i++) begin
            fetch(1, 32'h8000_0000 + 32'(i * 4), lat, ins);
            check("seq_inst", ins, mem_word(32'h8000_0000 + 32'(i * 4)));
        end
        @(negedge clk);
        check("seq_miss_cnt", miss_cnt1, 32'd13);
        check("seq_hit_cnt", hit_cnt1, 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
